// File: rtl/i2c_bus_frontend.sv
// I2C pin front end: 2-flop sync + level filter per line, START/STOP decode and
// byte/ACK assembly so downstream logic sees byte events instead of pin levels.

module i2c_line_filter #(
    parameter int FILTER_LEN = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_i,
    output logic filt_o
);
    localparam logic [4:0] FL = 5'(FILTER_LEN);

    logic       s1_q, s2_q, filt_q, filt_d;
    logic [3:0] cnt_q, cnt_d;
    logic [4:0] cnt_inc;

    assign cnt_inc = {1'b0, cnt_q} + 5'd1;

    always_comb begin
        filt_d = filt_q;
        cnt_d  = cnt_q;
        if (s2_q == filt_q) begin
            cnt_d = '0;
        end else if (cnt_inc == FL) begin
            filt_d = s2_q;
            cnt_d  = '0;
        end else begin
            cnt_d = cnt_inc[3:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q   <= 1'b1;
            s2_q   <= 1'b1;
            filt_q <= 1'b1;
            cnt_q  <= '0;
        end else begin
            s1_q   <= raw_i;
            s2_q   <= s1_q;
            filt_q <= filt_d;
            cnt_q  <= cnt_d;
        end
    end

    assign filt_o = filt_q;
endmodule

module i2c_bus_frontend #(
    parameter int FILTER_LEN = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl,
    input  logic       sda,
    output logic       scl_clean,
    output logic       sda_clean,
    output logic       start_det,
    output logic       stop_det,
    output logic       bus_busy,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       byte_ack,
    output logic       byte_first,
    output logic       bus_error
);
    localparam int NUM_LINES = 2;

    typedef enum logic [1:0] {IDLE, BITS, ACK} state_t;

    logic [NUM_LINES-1:0] raw_lines, filt_lines;
    assign raw_lines = {sda, scl};

    for (genvar g = 0; g < NUM_LINES; g++) begin : g_line
        i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_filt (
            .clk   (clk),
            .reset (reset),
            .raw_i (raw_lines[g]),
            .filt_o(filt_lines[g])
        );
    end

    logic scl_f, sda_f;
    assign scl_f = filt_lines[0];
    assign sda_f = filt_lines[1];

    state_t     state_q, state_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shreg_q, shreg_d;
    logic       first_q, first_d;
    logic       scl_p_q, sda_p_q;
    logic       start_q, start_d, stop_q, stop_d, err_q, err_d, bv_q, bv_d;
    logic       busy_q, busy_d;
    logic [7:0] data_q, data_d;
    logic       ack_q, ack_d, bfirst_q, bfirst_d;

    logic start_c, stop_c, rise_c, mid_byte;

    // SDA moving together with an SCL rise is a data sample, never START/STOP:
    // both conditions demand SCL high in the previous sample too.
    assign start_c  = scl_p_q & scl_f & sda_p_q & ~sda_f;
    assign stop_c   = scl_p_q & scl_f & ~sda_p_q & sda_f;
    assign rise_c   = ~scl_p_q & scl_f;
    assign mid_byte = ((state_q == BITS) && (bit_cnt_q != 4'd0)) || (state_q == ACK);

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        first_d   = first_q;
        busy_d    = busy_q;
        data_d    = data_q;
        ack_d     = ack_q;
        bfirst_d  = bfirst_q;
        start_d   = 1'b0;
        stop_d    = 1'b0;
        err_d     = 1'b0;
        bv_d      = 1'b0;
        if (start_c) begin
            state_d   = BITS;
            bit_cnt_d = '0;
            first_d   = 1'b1;
            start_d   = 1'b1;
            busy_d    = 1'b1;
            err_d     = mid_byte;
        end else if (stop_c) begin
            state_d = IDLE;
            stop_d  = 1'b1;
            busy_d  = 1'b0;
            err_d   = mid_byte;
        end else if (rise_c) begin
            case (state_q)
                BITS: begin
                    shreg_d   = {shreg_q[6:0], sda_f};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd7) state_d = ACK;
                end
                ACK: begin
                    data_d    = shreg_q;
                    ack_d     = ~sda_f;
                    bfirst_d  = first_q;
                    bv_d      = 1'b1;
                    first_d   = 1'b0;
                    bit_cnt_d = '0;
                    state_d   = BITS;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            first_q   <= 1'b0;
            scl_p_q   <= 1'b1;
            sda_p_q   <= 1'b1;
            start_q   <= 1'b0;
            stop_q    <= 1'b0;
            err_q     <= 1'b0;
            bv_q      <= 1'b0;
            busy_q    <= 1'b0;
            data_q    <= '0;
            ack_q     <= 1'b0;
            bfirst_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            first_q   <= first_d;
            scl_p_q   <= scl_f;
            sda_p_q   <= sda_f;
            start_q   <= start_d;
            stop_q    <= stop_d;
            err_q     <= err_d;
            bv_q      <= bv_d;
            busy_q    <= busy_d;
            data_q    <= data_d;
            ack_q     <= ack_d;
            bfirst_q  <= bfirst_d;
        end
    end

    assign scl_clean  = scl_f;
    assign sda_clean  = sda_f;
    assign start_det  = start_q;
    assign stop_det   = stop_q;
    assign bus_error  = err_q;
    assign byte_valid = bv_q;
    assign bus_busy   = busy_q;
    assign byte_data  = data_q;
    assign byte_ack   = ack_q;
    assign byte_first = bfirst_q;
endmodule
